sbqm_ctrl: RTL and testbench

Sequencing controller for the smart queue (SBQM) datapath. It turns the raw entry photocell into debounced single-cycle `up` pulses for the people counter, and arbitrates "next customer" requests from up to three tellers round-robin, issuing `down` pulses and a teller call number. It also derives the active-teller count `tcount` that feeds the wait-time ROM. It sits between the sensors and teller buttons on one side, and the counter/ROM datapath on the other.

---
 rtl/sbqm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sbqm_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sbqm_ctrl.sv
// Smart-queue sequencer: debounces the entry photocell into counter increments,
// arbitrates teller "next customer" requests round-robin into decrements and call numbers.
module sbqm_ctrl #(
  parameter int unsigned N         = 3,
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sens_in,
  input  logic [2:0]   tel_req,
  input  logic [2:0]   tel_en,
  input  logic [N-1:0] pcount,
  output logic         up,
  output logic         down,
  output logic [2:0]   tel_ack,
  output logic [1:0]   call_id,
  output logic [1:0]   tcount,
  output logic         rej
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic             sync1, s, db;
  logic [CNT_W-1:0] db_cnt;
  logic             db_rise_c;
  logic             arr_pend, arr_take;
  logic [1:0]       last_q, start_c;
  logic [2:0]       elig, rot;
  logic [1:0]       off_c, grant_idx;
  logic [2:0]       sum_c;
  logic [2:0]       ack_onehot;
  logic             grant;
  logic             up_d, down_d, rej_d;
  logic [2:0]       ack_d;
  logic             pc_full, pc_empty;

  // Two-flop synchronizer for the asynchronous photocell
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= sens_in;
      s     <= sync1;
    end
  end

  // Debounce: accept a level only after DB_CYCLES consecutive mismatching samples
  assign db_rise_c = s && !db && (db_cnt == CNT_W'(DB_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db     <= 1'b0;
      db_cnt <= '0;
    end else if (s == db) begin
      db_cnt <= '0;
    end else if (db_cnt == CNT_W'(DB_CYCLES - 1)) begin
      db     <= s;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + CNT_W'(1);
    end
  end

  // Single-entry arrival latch; a rise in the consuming cycle is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) arr_pend <= 1'b0;
    else      arr_pend <= (arr_pend && !arr_take) || db_rise_c;
  end

  assign pc_full  = &pcount;
  assign pc_empty = (pcount == '0);

  // Round-robin search: rotate eligible set so the start teller sits at bit 0
  assign elig    = tel_req & tel_en;
  assign start_c = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;

  always_comb begin
    rot = elig;
    case (start_c)
      2'd1:    rot = {elig[0], elig[2:1]};
      2'd2:    rot = {elig[1:0], elig[2]};
      default: rot = elig;
    endcase
  end

  always_comb begin
    off_c = 2'd2;
    if (rot[0])      off_c = 2'd0;
    else if (rot[1]) off_c = 2'd1;
  end

  assign sum_c     = {1'b0, start_c} + {1'b0, off_c};
  assign grant_idx = (sum_c >= 3'd3) ? 2'(sum_c - 3'd3) : 2'(sum_c);

  always_comb begin
    ack_onehot = 3'b001;
    case (grant_idx)
      2'd1:    ack_onehot = 3'b010;
      2'd2:    ack_onehot = 3'b100;
      default: ack_onehot = 3'b001;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state and pulse decisions; arrivals outrank grants
  always_comb begin
    state_d  = state_q;
    up_d     = 1'b0;
    down_d   = 1'b0;
    rej_d    = 1'b0;
    ack_d    = 3'b000;
    arr_take = 1'b0;
    grant    = 1'b0;
    case (state_q)
      IDLE: begin
        if (arr_pend) begin
          arr_take = 1'b1;
          if (pc_full) begin
            rej_d = 1'b1;
          end else begin
            up_d    = 1'b1;
            state_d = SETTLE;
          end
        end else if ((elig != 3'b000) && !pc_empty) begin
          grant   = 1'b1;
          down_d  = 1'b1;
          ack_d   = ack_onehot;
          state_d = SETTLE;
        end
      end
      SETTLE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; teller 0 leads after reset because the pointer starts at 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      up      <= 1'b0;
      down    <= 1'b0;
      rej     <= 1'b0;
      tel_ack <= 3'b000;
      call_id <= 2'd0;
      tcount  <= 2'd0;
      last_q  <= 2'd2;
    end else begin
      up      <= up_d;
      down    <= down_d;
      rej     <= rej_d;
      tel_ack <= ack_d;
      tcount  <= 2'(tel_en[0]) + 2'(tel_en[1]) + 2'(tel_en[2]);
      if (grant) begin
        call_id <= grant_idx + 2'd1;
        last_q  <= grant_idx;
      end
    end
  end

endmodule

// File: tb/tb_sbqm_ctrl.sv
// Directed bench for sbqm_ctrl: debounce timing, full-queue reject, round robin,
// blocked grants, arrival/grant collision and asynchronous reset.
module tb_sbqm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sens_in;
  logic [2:0] tel_req;
  logic [2:0] tel_en;
  logic [2:0] pcount;
  logic       up, down, rej;
  logic [2:0] tel_ack;
  logic [1:0] call_id, tcount;

  int checks   = 0;
  int failures = 0;
  bit model_en = 1'b0;

  always #5 clk = ~clk;

  sbqm_ctrl #(.N(3), .DB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .sens_in (sens_in),
    .tel_req (tel_req),
    .tel_en  (tel_en),
    .pcount  (pcount),
    .up      (up),
    .down    (down),
    .tel_ack (tel_ack),
    .call_id (call_id),
    .tcount  (tcount),
    .rej     (rej)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pulses(input string tag, input logic e_up, input logic e_down,
                        input logic [2:0] e_ack, input logic e_rej);
    chk({tag, ".up"},   8'(up),      8'(e_up));
    chk({tag, ".down"}, 8'(down),    8'(e_down));
    chk({tag, ".ack"},  8'(tel_ack), 8'(e_ack));
    chk({tag, ".rej"},  8'(rej),     8'(e_rej));
  endtask

  // Advance one cycle and sample 1 ns after the edge; the counter model follows pulses
  task automatic step();
    @(posedge clk);
    #1;
    if (model_en) begin
      if (up)   pcount = pcount + 3'd1;
      if (down) pcount = pcount - 3'd1;
    end
  endtask

  logic [2:0] rr_ack  [8];
  logic [1:0] rr_call [8];

  initial begin
    rr_ack  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    rr_call = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd1, 2'd1};

    rst = 1'b1; sens_in = 1'b0; tel_req = 3'b000; tel_en = 3'b000; pcount = 3'd0;
    #1 rst = 1'b0;
    #1;
    pulses("reset", 1'b0, 1'b0, 3'b000, 1'b0);
    chk("reset.call_id", 8'(call_id), 8'd0);
    chk("reset.tcount",  8'(tcount),  8'd0);
    repeat (3) step();
    rst = 1'b0;
    rst = 1'b1;
    pcount = 3'd2;
    repeat (2) step();

    // Held photocell: one up in cycle DB_CYCLES+3
    sens_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      pulses($sformatf("deb%0d", i), 1'(i == 7), 1'b0, 3'b000, 1'b0);
    end
    sens_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      pulses($sformatf("deb_fall%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Two-cycle glitch is rejected
    sens_in = 1'b1;
    repeat (2) step();
    sens_in = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      pulses($sformatf("glitch%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Full queue rejects the arrival
    pcount = 3'd7;
    sens_in = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      pulses($sformatf("full%0d", i), 1'b0, 1'b0, 3'b000, 1'(i == 7));
    end
    sens_in = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      pulses($sformatf("full_fall%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Disabled requester is never served
    chk("tcount0", 8'(tcount), 8'd0);
    tel_en = 3'b101;
    pcount = 3'd3;
    tel_req = 3'b010;
    step();
    chk("tcount2", 8'(tcount), 8'd2);
    pulses("dis0", 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      pulses($sformatf("dis%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Empty queue blocks grants
    tel_en = 3'b111;
    pcount = 3'd0;
    step();
    chk("tcount3", 8'(tcount), 8'd3);
    pulses("empty0", 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      pulses($sformatf("empty%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end
    tel_req = 3'b000;
    step();

    // Round robin with all three tellers requesting
    pcount = 3'd5;
    model_en = 1'b1;
    tel_req = 3'b111;
    for (int i = 0; i < 8; i++) begin
      step();
      pulses($sformatf("rr%0d", i), 1'b0, 1'(rr_ack[i] != 3'b000), rr_ack[i], 1'b0);
      chk($sformatf("rr%0d.call_id", i), 8'(call_id), 8'(rr_call[i]));
    end
    tel_req = 3'b000;
    step();
    pulses("rr_end", 1'b0, 1'b0, 3'b000, 1'b0);

    // Arrival and request in the same cycle: up first, grant two cycles later
    pcount = 3'd3;
    sens_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      pulses($sformatf("col%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end
    tel_req = 3'b001;
    step();
    pulses("col7", 1'b1, 1'b0, 3'b000, 1'b0);
    step();
    pulses("col8", 1'b0, 1'b0, 3'b000, 1'b0);
    step();
    pulses("col9", 1'b0, 1'b1, 3'b001, 1'b0);
    chk("col9.call_id", 8'(call_id), 8'd1);
    tel_req = 3'b000;
    sens_in = 1'b0;
    for (int i = 10; i <= 19; i++) begin
      step();
      pulses($sformatf("col%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    // Asynchronous reset while up is high
    model_en = 1'b0;
    pcount = 3'd2;
    sens_in = 1'b1;
    for (int i = 1; i <= 7; i++) step();
    pulses("ar_pre", 1'b1, 1'b0, 3'b000, 1'b0);
    #2 rst = 1'b0;
    sens_in = 1'b0;
    tel_en = 3'b011;
    #1;
    pulses("ar_now", 1'b0, 1'b0, 3'b000, 1'b0);
    chk("ar_now.call_id", 8'(call_id), 8'd0);
    chk("ar_now.tcount",  8'(tcount),  8'd0);
    repeat (2) step();
    chk("ar_hold.tcount", 8'(tcount), 8'd0);
    rst = 1'b1;
    chk("ar_rel.tcount", 8'(tcount), 8'd0);
    step();
    chk("ar_post.tcount",  8'(tcount),  8'd2);
    chk("ar_post.call_id", 8'(call_id), 8'd0);
    for (int i = 1; i <= 10; i++) begin
      step();
      pulses($sformatf("ar_post%0d", i), 1'b0, 1'b0, 3'b000, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
